// File: rtl/uart_tx.sv
// Transmit-only 8N1 UART serializer: start bit, 8 data bits LSB first, stop bit.
// BAUD clock cycles per bit; start is level-sensitive and registered before use.
module uart_tx #(
  parameter int unsigned BAUD = 434
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] data,
  input  logic       start,
  output logic       ready,
  output logic       tx
);

  localparam int unsigned CntW = (BAUD > 1) ? $clog2(BAUD) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BAUD - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StTrans} state_e;

  state_e          state_q, state_d;
  logic [9:0]      shift_q, shift_d;
  logic [CntW-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic            start_r_q;
  logic            ready_q, ready_d;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    unique case (state_q)
      StIdle: begin
        baud_cnt_d = '0;
        if (start_r_q) state_d = StLoad;
      end
      StLoad: begin
        shift_d    = {1'b1, data, 1'b0};
        bit_cnt_d  = '0;
        baud_cnt_d = '0;
        state_d    = StTrans;
      end
      StTrans: begin
        if (baud_cnt_q == CntMax) begin
          baud_cnt_d = '0;
          // Ones shift in behind the frame, so the line rests high once it has drained.
          shift_d    = {1'b1, shift_q[9:1]};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) state_d = StIdle;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q    <= StIdle;
      shift_q    <= '1;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      start_r_q  <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      start_r_q  <= start;
      ready_q    <= ready_d;
    end
  end

  assign tx    = shift_q[0];
  assign ready = ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: time-based frame model checked every cycle, a line receiver,
// directed scenarios with literal expectations, then randomized start/data/reset traffic.
module tb_uart_tx;

  localparam int unsigned BAUD = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx, ready;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx #(.BAUD(BAUD)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .data  (data),
    .start (start),
    .ready (ready),
    .tx    (tx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: edge n counts rising edges since the last reset edge. A request seen idle at
  // edge n-1 makes edge n the load edge; the frame occupies edges n+1 .. n+10*BAUD.
  int         n = 0;
  int         busy_end = 0;
  int         trans_start = -1000000;
  bit         prev_s = 1'b0;
  logic [7:0] cur_byte = 8'h00;
  bit         exp_tx = 1'b1;
  bit         exp_ready = 1'b1;
  bit         model_valid = 1'b0;

  initial forever begin
    @(posedge clk);
    if (rstn) begin
      n = 0;
      busy_end = 0;
      trans_start = -1000000;
      prev_s = 1'b0;
      model_valid = 1'b1;
    end else begin
      n++;
      if (n == trans_start) cur_byte = data;
      if (n - 1 >= busy_end && prev_s) begin
        trans_start = n + 1;
        busy_end = n + 1 + 10 * int'(BAUD);
      end
      prev_s = start;
    end
    exp_ready = (n >= busy_end);
    if (n >= trans_start && n < busy_end) begin
      logic [9:0] frame;
      frame = {1'b1, cur_byte, 1'b0};
      exp_tx = frame[(n - trans_start) / int'(BAUD)];
    end else begin
      exp_tx = 1'b1;
    end
  end

  // Per-cycle compare plus a mid-bit sampling receiver on the line.
  logic [7:0] rx_q[$];
  bit         rx_busy = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'h00;

  initial forever begin
    @(negedge clk);
    if (model_valid) begin
      check("tx_vs_model", 32'(tx), 32'(exp_tx));
      check("ready_vs_model", 32'(ready), 32'(exp_ready));
    end
    if (rstn) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (tx === 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % int'(BAUD) == int'(BAUD) / 2) begin
        int i;
        i = rx_cnt / int'(BAUD);
        if (i >= 1 && i <= 8) begin
          rx_sh[i-1] = tx;
        end else if (i == 9) begin
          rx_q.push_back(rx_sh);
          rx_busy = 1'b0;
        end
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(input int cnt);
    int b = 0;
    while (rx_q.size() < cnt && b < 2000) begin
      @(negedge clk);
      b++;
    end
    check("rx_frame_count", 32'(rx_q.size()), 32'(cnt));
  endtask

  task automatic wait_ready(input string name);
    int b = 0;
    while (ready !== 1'b1 && b < 2000) begin
      @(negedge clk);
      b++;
    end
    check(name, 32'(ready), 32'd1);
  endtask

  initial begin
    int base, len, hi, b, run;

    // Reset then a long quiet idle stretch.
    rstn = 1'b1;
    step(3);
    rstn = 1'b0;
    step(100);
    check("idle_tx", 32'(tx), 32'd1);
    check("idle_ready", 32'(ready), 32'd1);

    // Single 1-cycle pulse, data 8'h55; ready drops two edges after the drive edge.
    base = rx_q.size();
    data = 8'h55;
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("ready_still_high", 32'(ready), 32'd1);
    step(1);
    check("ready_low_at_load", 32'(ready), 32'd0);
    wait_rx(base + 1);
    check("byte_55", 32'(rx_q[base]), 32'h55);
    wait_ready("ready_after_55");
    step(5);

    // Bit order for 8'h0A and frame length from start bit to ready.
    base = rx_q.size();
    data = 8'h0A;
    start = 1'b1;
    step(1);
    start = 1'b0;
    b = 0;
    while (tx !== 1'b0 && b < 100) begin
      @(negedge clk);
      b++;
    end
    len = 0;
    do begin
      @(negedge clk);
      len++;
    end while (ready !== 1'b1 && len < 200);
    check("frame_len_0a", 32'(len), 32'd40);
    wait_rx(base + 1);
    check("byte_0a", 32'(rx_q[base]), 32'h0A);
    step(5);

    // Back-to-back with start held; data changes during the first frame.
    base = rx_q.size();
    data = 8'h41;
    start = 1'b1;
    step(20);
    data = 8'h0A;
    wait_rx(base + 1);
    wait_ready("ready_between_frames");
    hi = 0;
    while (ready === 1'b1 && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    check("ready_gap_cycles", 32'(hi), 32'd1);
    start = 1'b0;
    wait_rx(base + 2);
    check("b2b_first_41", 32'(rx_q[base]), 32'h41);
    check("b2b_second_0a", 32'(rx_q[base+1]), 32'h0A);
    wait_ready("ready_after_b2b");
    step(10);
    check("no_third_frame", 32'(rx_q.size()), 32'(base + 2));

    // Data captured at load; later changes ignored.
    step(1);
    base = rx_q.size();
    data = 8'hFF;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(10);
    data = 8'h00;
    wait_rx(base + 1);
    check("byte_ff_stable", 32'(rx_q[base]), 32'hFF);
    wait_ready("ready_after_ff");
    step(5);

    // Reset during data bit 3 aborts the frame.
    base = rx_q.size();
    data = 8'hC3;
    start = 1'b1;
    step(1);
    start = 1'b0;
    b = 0;
    while (tx !== 1'b0 && b < 100) begin
      @(negedge clk);
      b++;
    end
    step(17);
    rstn = 1'b1;
    step(1);
    check("abort_tx_high", 32'(tx), 32'd1);
    check("abort_ready_high", 32'(ready), 32'd1);
    rstn = 1'b0;
    step(60);
    check("abort_no_frame", 32'(rx_q.size()), 32'(base));
    check("abort_idle_ready", 32'(ready), 32'd1);

    // Randomized traffic: random start runs, data every cycle, occasional reset.
    for (int c = 0; c < 3000; c += run) begin
      run = int'($urandom_range(1, 60));
      start = 1'(($urandom_range(0, 2)) == 0);
      for (int k = 0; k < run; k++) begin
        data = 8'($urandom);
        rstn = ($urandom_range(0, 299) == 0);
        step(1);
      end
    end
    rstn = 1'b0;
    start = 1'b0;
    step(100);
    check("final_ready", 32'(ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
